// File: rtl/fb_pkg.sv
// Shared constants and types for the scope framebuffer arbiter.
// Optional clear engine is enabled by defining FB_CLEAR_EN.
package fb_pkg;

  localparam int unsigned H_PIX          = 640;
  localparam int unsigned V_PIX          = 480;
  localparam int unsigned PIX_W          = 4;
  localparam int unsigned PPW            = 4;
  localparam int unsigned ADDR_W         = 17;
  localparam int unsigned WORDS_PER_LINE = 160;
  localparam int unsigned FB_WORDS       = 76800;

  typedef logic [PIX_W-1:0]     pixel_t;
  typedef logic [PIX_W*PPW-1:0] word_t;
  typedef logic [ADDR_W-1:0]    addr_t;

  typedef enum logic [2:0] {
    IDLE,
    PRE0,
    PRE1,
    PRE2,
    SCAN
  } state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Framebuffer word address: y*160 + word, built from shifts at 17 bits.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic [9:0]        y,
  input  logic [7:0]        word,
  output logic [ADDR_W-1:0] addr
);

  // y*160 = (y<<7) + (y<<5)
  always_comb begin
    addr = ({7'd0, y} << 7) + ({7'd0, y} << 5) + {9'd0, word};
  end

endmodule

// File: rtl/scope_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scanout prefetch has hard priority,
// the scope trace writer gets every remaining memory slot.
// Define FB_CLEAR_EN to add the clr_req/clr_busy framebuffer clear engine.
module scope_fb_arbiter
  import fb_pkg::*;
(
  input  logic        pclk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [9:0]  disp_y,
  input  logic [9:0]  disp_x,
  input  logic        disp_active,
  output logic [3:0]  pixel,
  input  logic        wr_req,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [3:0]  wr_pixel,
  output logic        wr_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [15:0] mem_wdata,
`ifdef FB_CLEAR_EN
  input  logic        clr_req,
  output logic        clr_busy,
`endif
  input  logic [15:0] mem_rdata
);

  state_t      state;
  word_t       cur_word;
  word_t       next_word;
  logic [7:0]  rd_cnt;
  logic [9:0]  line_y;
  logic        rd_pend;
  logic        ack_d;

  logic        line_go;
  logic        last_pix;
  logic        word_end;
  logic        disp_slot;
  logic        pre_rd;
  logic        wr_in_range;
  logic        wr_gnt;
  logic        clr_block;
  logic [7:0]  rd_word;
  addr_t       scan_addr;
  addr_t       wr_addr;

  assign line_go     = line_start && (disp_y < 10'(V_PIX));
  assign last_pix    = disp_active && (disp_x == 10'(H_PIX - 1));
  assign word_end    = (state == SCAN) && disp_active && (disp_x[1:0] == 2'd3);
  assign disp_slot   = word_end && (rd_cnt < 8'(WORDS_PER_LINE));
  assign pre_rd      = (state == PRE0) || (state == PRE1);
  assign wr_in_range = (wr_x < 10'(H_PIX)) && (wr_y < 10'(V_PIX));
  assign rd_word     = (state == PRE0) ? 8'd0 : (state == PRE1) ? 8'd1 : rd_cnt;

`ifdef FB_CLEAR_EN
  addr_t clr_addr;
  assign clr_block = clr_busy || clr_req;
`else
  assign clr_block = 1'b0;
`endif

  assign wr_gnt = wr_req && !ack_d && !clr_block;

  fb_addr_gen u_scan_addr (
    .y    (line_y),
    .word (rd_word),
    .addr (scan_addr)
  );

  fb_addr_gen u_wr_addr (
    .y    (wr_y),
    .word (wr_x[9:2]),
    .addr (wr_addr)
  );

  // Memory port mux: display reads first, then clear engine, then writer
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    if (!rst) begin
      if (pre_rd || disp_slot) begin
        mem_en   = 1'b1;
        mem_addr = scan_addr;
      end
`ifdef FB_CLEAR_EN
      else if (clr_busy) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_be    = '1;
        mem_wdata = '0;
      end
`endif
      else if (wr_gnt) begin
        wr_ack = 1'b1;
        if (wr_in_range) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_be    = 4'b0001 << wr_x[1:0];
          mem_wdata = {4{wr_pixel}};
        end
      end
    end
  end

  // Scan FSM, line prefetch and word pipeline
  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= IDLE;
      cur_word  <= '0;
      next_word <= '0;
      rd_cnt    <= '0;
      line_y    <= '0;
      rd_pend   <= 1'b0;
      ack_d     <= 1'b0;
    end else begin
      ack_d   <= wr_ack;
      rd_pend <= disp_slot;
      if (rd_pend) begin
        next_word <= mem_rdata;
      end
      case (state)
        IDLE: ;
        PRE0: begin
          rd_cnt <= 8'd1;
          state  <= PRE1;
        end
        PRE1: begin
          cur_word <= mem_rdata;
          state    <= PRE2;
        end
        PRE2: begin
          next_word <= mem_rdata;
          rd_cnt    <= 8'd2;
          state     <= SCAN;
        end
        SCAN: begin
          if (word_end) begin
            cur_word <= next_word;
          end
          if (disp_slot) begin
            rd_cnt <= rd_cnt + 8'd1;
          end
          if (last_pix) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A new visible line restarts the prefetch from any state
      if (line_go) begin
        state   <= PRE0;
        line_y  <= disp_y;
        rd_pend <= 1'b0;
      end
    end
  end

`ifdef FB_CLEAR_EN
  // Clear engine: walks every word using slots the display leaves free
  always_ff @(posedge pclk) begin
    if (rst) begin
      clr_busy <= 1'b0;
      clr_addr <= '0;
    end else if (clr_req) begin
      clr_busy <= 1'b1;
      clr_addr <= '0;
    end else if (clr_busy && !pre_rd && !disp_slot) begin
      if (clr_addr == 17'(FB_WORDS - 1)) begin
        clr_busy <= 1'b0;
      end
      clr_addr <= clr_addr + 17'd1;
    end
  end
`endif

  // Pixel select from the registered current word
  always_comb begin
    pixel = '0;
    if ((state == SCAN) && disp_active) begin
      case (disp_x[1:0])
        2'd0:    pixel = cur_word[3:0];
        2'd1:    pixel = cur_word[7:4];
        2'd2:    pixel = cur_word[11:8];
        default: pixel = cur_word[15:12];
      endcase
    end
  end

endmodule

// File: tb/tb_scope_fb_arbiter.sv
// Self-checking bench for scope_fb_arbiter with a behavioural sync RAM.
module tb_scope_fb_arbiter;
  import fb_pkg::*;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic [9:0]  disp_y = '0;
  logic [9:0]  disp_x = '0;
  logic        disp_active = 1'b0;
  logic [3:0]  pixel;
  logic        wr_req = 1'b0;
  logic [9:0]  wr_x = '0;
  logic [9:0]  wr_y = '0;
  logic [3:0]  wr_pixel = '0;
  logic        wr_ack;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [3:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
`ifdef FB_CLEAR_EN
  logic        clr_req = 1'b0;
  logic        clr_busy;
`endif

  int checks = 0;
  int failures = 0;
  int rd_count = 0;
  int clr_count = 0;

  logic [15:0] ram [0:76799];

  scope_fb_arbiter dut (
    .pclk        (pclk),
    .rst         (rst),
    .line_start  (line_start),
    .disp_y      (disp_y),
    .disp_x      (disp_x),
    .disp_active (disp_active),
    .pixel       (pixel),
    .wr_req      (wr_req),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_pixel    (wr_pixel),
    .wr_ack      (wr_ack),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
`ifdef FB_CLEAR_EN
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
`endif
    .mem_rdata   (mem_rdata)
  );

  always #5 pclk = ~pclk;

  // Synchronous single-port RAM with nibble enables
  always @(posedge pclk) begin
    if (mem_en && (int'(mem_addr) < 76800)) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) ram[mem_addr][i*4 +: 4] <= mem_wdata[i*4 +: 4];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  always @(posedge pclk) begin
    if (mem_en && !mem_we) rd_count++;
    if (mem_en && mem_we && mem_be == 4'hF && mem_wdata == 16'h0000) clr_count++;
  end

  function automatic logic [15:0] gold(input int a);
    if (a == 0) return 16'h4321;
    if (a == 1) return 16'h8765;
    if (a == 76799) return 16'hFEDC;
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  function automatic int exp_pix(input int y, input int x);
    logic [15:0] w;
    w = gold(y * 160 + x / 4);
    return int'(w[(x % 4) * 4 +: 4]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  typedef struct {
    int          x;
    int          y;
    logic [3:0]  p;
    int          ack;
    int          en;
    int          addr;
    int          be;
    int          wd;
  } wvec_t;

  wvec_t wv [6];

  // mode: 0 plain, 1 reset at x=100, 2 writer hits slot at x=7, 3 writer during prefetch
  task automatic do_line(input int y, input int mode);
    int rd_base;
    bit reset_seen;
    int exp;
    reset_seen = 0;
    line_start = 1'b1;
    disp_y = 10'(y);
    disp_active = 1'b0;
    disp_x = '0;
    step();
    line_start = 1'b0;
    rd_base = rd_count;
    if (mode == 3) begin
      wr_req = 1'b1; wr_x = 10'd3; wr_y = 10'd3; wr_pixel = 4'h9;
      @(negedge pclk); chk("pre0_ack", int'(wr_ack), 0);
      step();
      @(negedge pclk); chk("pre1_ack", int'(wr_ack), 0);
      step();
      @(negedge pclk);
      chk("pre2_ack", int'(wr_ack), 1);
      chk("pre2_addr", int'(mem_addr), 480);
      chk("pre2_be", int'(mem_be), 8);
      chk("pre2_wdata", int'(mem_wdata), 16'h9999);
      step();
      wr_req = 1'b0;
    end else begin
      repeat (3) step();
    end
    step();
    for (int x = 0; x < 640; x++) begin
      disp_active = 1'b1;
      disp_x = 10'(x);
      if (mode == 1 && x == 100) rst = 1'b1;
      if (mode == 2 && x == 7) begin
        wr_req = 1'b1; wr_x = 10'd5; wr_y = 10'd2; wr_pixel = 4'hA;
      end
      @(negedge pclk);
      exp = reset_seen ? 0 : exp_pix(y, x);
      chk("pixel", int'(pixel), exp);
      if (y == 0 && x < 8 && !reset_seen) chk("pix_tbl_first", int'(pixel), x + 1);
      if (y == 479 && x >= 636) chk("pix_tbl_last", int'(pixel), 12 + x - 636);
      if (mode == 2 && x == 7) begin
        chk("slot_ack", int'(wr_ack), 0);
        chk("slot_we", int'(mem_we), 0);
        chk("slot_en", int'(mem_en), 1);
      end
      if (mode == 2 && x == 8) begin
        chk("scan_wr_ack", int'(wr_ack), 1);
        chk("scan_wr_we", int'(mem_we), 1);
        chk("scan_wr_addr", int'(mem_addr), 321);
        chk("scan_wr_be", int'(mem_be), 2);
        chk("scan_wr_wdata", int'(mem_wdata), 16'hAAAA);
      end
      if (mode == 1 && x == 101) chk("rst_mem_en", int'(mem_en), 0);
      step();
      if (mode == 1 && x == 100) begin
        rst = 1'b0;
        reset_seen = 1;
      end
      if (mode == 2 && x == 8) wr_req = 1'b0;
    end
    disp_active = 1'b0;
    disp_x = '0;
    @(negedge pclk);
    chk("line_end_state", int'(dut.state), int'(IDLE));
    if (!reset_seen) chk("line_reads", rd_count - rd_base, 160);
    step();
  endtask

  initial begin
    logic [15:0] w321;
    int n;
    for (int a = 0; a < 76800; a++) ram[a] = gold(a);

    wv[0] = '{x: 0,   y: 0,   p: 4'h7, ack: 1, en: 1, addr: 0,     be: 1, wd: 16'h7777};
    wv[1] = '{x: 639, y: 479, p: 4'hF, ack: 1, en: 1, addr: 76799, be: 8, wd: 16'hFFFF};
    wv[2] = '{x: 6,   y: 10,  p: 4'h3, ack: 1, en: 1, addr: 1601,  be: 4, wd: 16'h3333};
    wv[3] = '{x: 700, y: 0,   p: 4'h1, ack: 1, en: 0, addr: 0,     be: 0, wd: 0};
    wv[4] = '{x: 0,   y: 480, p: 4'h2, ack: 1, en: 0, addr: 0,     be: 0, wd: 0};
    wv[5] = '{x: 640, y: 5,   p: 4'h4, ack: 1, en: 0, addr: 0,     be: 0, wd: 0};

    // reset with a writer request pending
    wr_req = 1'b1; wr_x = 10'd1; wr_y = 10'd1;
    step();
    @(negedge pclk);
    chk("rst_wr_ack", int'(wr_ack), 0);
    chk("rst_mem_en_hold", int'(mem_en), 0);
    wr_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    @(negedge pclk);
    chk("reset_state", int'(dut.state), int'(IDLE));
    chk("reset_pixel", int'(pixel), 0);
    chk("reset_mem_en", int'(mem_en), 0);
    chk("reset_wr_ack", int'(wr_ack), 0);
    step();

    do_line(0, 0);
    do_line(479, 0);
    do_line(1, 3);
    do_line(0, 2);
    w321 = gold(321);
    w321[7:4] = 4'hA;
    @(negedge pclk);
    chk("ram_321", int'(ram[321]), int'(w321));
    do_line(0, 1);
    do_line(0, 0);

    // off-screen line_start is ignored
    line_start = 1'b1; disp_y = 10'd500;
    step();
    line_start = 1'b0;
    @(negedge pclk);
    chk("ignored_ls_state", int'(dut.state), int'(IDLE));
    chk("ignored_ls_en", int'(mem_en), 0);
    step();

    // writer vectors in IDLE
    foreach (wv[i]) begin
      wr_req = 1'b1;
      wr_x = 10'(wv[i].x); wr_y = 10'(wv[i].y); wr_pixel = wv[i].p;
      @(negedge pclk);
      chk("wv_ack", int'(wr_ack), wv[i].ack);
      chk("wv_en", int'(mem_en), wv[i].en);
      if (wv[i].en != 0) begin
        chk("wv_we", int'(mem_we), 1);
        chk("wv_addr", int'(mem_addr), wv[i].addr);
        chk("wv_be", int'(mem_be), wv[i].be);
        chk("wv_wdata", int'(mem_wdata), wv[i].wd);
      end
      step();
      wr_req = 1'b0;
      step();
    end

    // held request: ack, one ignored cycle, ack again
    wr_req = 1'b1; wr_x = 10'd10; wr_y = 10'd0; wr_pixel = 4'h1;
    @(negedge pclk); chk("hold_ack1", int'(wr_ack), 1);
    step();
    @(negedge pclk); chk("hold_gap", int'(wr_ack), 0);
    chk("hold_gap_en", int'(mem_en), 0);
    step();
    @(negedge pclk); chk("hold_ack2", int'(wr_ack), 1);
    step();
    wr_req = 1'b0;
    step();

`ifdef FB_CLEAR_EN
    clr_req = 1'b1;
    wr_req = 1'b1; wr_x = 10'd1; wr_y = 10'd0; wr_pixel = 4'h5;
    @(negedge pclk); chk("clr_req_ack", int'(wr_ack), 0);
    step();
    clr_req = 1'b0;
    clr_count = 0;
    n = 0;
    while (n < 80000) begin
      @(negedge pclk);
      if (!clr_busy) break;
      if (wr_ack) chk("clr_ack_withheld", int'(wr_ack), 0);
      step();
      n++;
    end
    chk("clr_done_in_time", int'(n < 80000), 1);
    chk("clr_write_count", clr_count, 76800);
    chk("clr_then_ack", int'(wr_ack), 1);
    chk("clr_then_addr", int'(mem_addr), 0);
    chk("clr_then_be", int'(mem_be), 2);
    step();
    wr_req = 1'b0;
    @(negedge pclk);
    chk("clr_ram_last", int'(ram[76799]), 0);
    chk("clr_ram_mid", int'(ram[321]), 0);
    chk("clr_ram_0", int'(ram[0]), 16'h0050);
    step();
`else
    n = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scope_fb_arbiter.md
Name: scope_fb_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between VGA scanout (read, hard real-time) and the scope trace writer (pixel writes, best-effort).
Packs 4 pixels of 4 bits each into each 16-bit word, giving 160 words/line and 76800 words total.
Prefetches each visible line two words ahead and delivers a 4-bit pixel in the same cycle as the scan coordinate.
Writer receives every memory slot the scanout does not need.

Parameters:
H_PIX, 640, visible pixels per line
V_PIX, 480, visible lines
PIX_W, 4, bits per pixel
PPW, 4, pixels per memory word
ADDR_W, 17, memory word address width

Ports:
pclk  in  1  pixel clock, sole clock
rst  in  1  reset; one clock; reset is synchronous and active-high
line_start  in  1  one-cycle pulse ≥4 cycles before first active pixel of a line; disp_y valid with it
disp_y  in  10  scan line (visible-relative)
disp_x  in  10  scan pixel (visible-relative)
disp_active  in  1  disp_x/disp_y inside visible area
pixel  out  4  pixel for current disp_x
wr_req  in  1  writer request; hold with stable data until wr_ack
wr_x  in  10  writer pixel x
wr_y  in  10  writer pixel y
wr_pixel  in  4  writer pixel value
wr_ack  out  1  one-cycle pulse, write completed/dropped
mem_en  out  1  memory access strobe
mem_we  out  1  write when 1
mem_addr  out  17  word address
mem_be  out  4  nibble write enables
mem_wdata  out  16  write data
mem_rdata  in  16  read data, valid cycle after mem_en&!mem_we

Behaviour:
- Reset (sync): state IDLE; cur_word, next_word, pixel = 0; wr_ack, mem_en, mem_we = 0; mem_be = 0; rd_cnt = 0. Reset mid-line aborts scan; output is 0 until next line_start.
- States:
  - IDLE.
  - PRE0: issue read at base = disp_y*160; rd_cnt = 1.
  - PRE1: issue read at base+1; capture word 0 into cur_word.
  - PRE2: capture word 1 into next_word; rd_cnt = 2.
  - SCAN.
- Transitions:
  - IDLE -> PRE0 on line_start with disp_y < V_PIX. line_start with disp_y ≥ V_PIX is ignored.
  - PRE0 -> PRE1 -> PRE2 -> SCAN, unconditional.
  - SCAN -> IDLE after the disp_active cycle with disp_x = H_PIX-1.
  - line_start in any state restarts at PRE0.
- SCAN, cycle with disp_active and disp_x[1:0] = 3:
  - cur_word <= next_word.
  - If rd_cnt < 160: issue read at base+rd_cnt and increment rd_cnt. Data is captured into next_word the following cycle.
  - These are display slots.
- pixel = cur_word nibble selected by disp_x[1:0] (nibble 0 = bits 3:0), registered word plus combinational mux. pixel = 0 when !disp_active.
- Writer:
  - Granted in any cycle that is not a display slot and not PRE0/PRE1.
  - On grant: mem_en = 1, mem_we = 1, mem_addr = wr_y*160 + wr_x[9:2], mem_be = one-hot(wr_x[1:0]), mem_wdata = wr_pixel replicated ×4, wr_ack = 1 in the same cycle.
  - wr_x ≥ H_PIX or wr_y ≥ V_PIX: wr_ack = 1, no memory access.
  - After wr_ack the arbiter ignores wr_req for one cycle, so there is no double write.
  - Worst-case writer wait: 2 cycles (prefetch) or 1 cycle (scan).
- Simultaneous events: a display access always wins over a writer access in the same cycle.
- Arithmetic: y*160 = (y<<7)+(y<<5), computed at 17 bits.

Optional Feature:
FB_CLEAR_EN:
- Adds input clr_req (pulse) and output clr_busy.
- On clr_req, clr_busy = 1 and a clear engine writes words 0..76799 with be = 1111 and data = 0, using writer slots. It has priority over wr_req; wr_ack is withheld while busy.
- clr_busy drops the cycle after word 76799 is written.
- clr_req while busy restarts the clear at 0.
- Without the macro: ports absent, no clear logic.

Decomposition:
- Package fb_pkg:
  - H_PIX, V_PIX, WORDS_PER_LINE = 160, FB_WORDS = 76800.
  - State enum {IDLE, PRE0, PRE1, PRE2, SCAN}.
  - Pixel/word typedefs.
- Sub-module fb_addr_gen: combinational (y, word index) -> 17-bit address, instanced twice (scan base, writer).

Test Plan:
- Preload RAM word 0 = 16'h4321, word 1 = 16'h8765. line_start with y = 0, then active x = 0..7 -> pixel = 1,2,3,4,5,6,7,8.
- Line y = 479, word 159 = 16'hFEDC -> pixel at x = 636..639 = C,D,E,F; exactly 160 reads issued; state IDLE after x = 639.
- wr_req x = 5, y = 2, pixel = A during SCAN at an x[1:0] = 3 slot -> wr_ack the next cycle; mem_addr = 321, mem_be = 0010, mem_wdata = AAAA.
- wr_req x = 700 -> wr_ack within 2 cycles, mem_en stays 0.
- rst asserted at x = 100 of a line -> next cycle pixel = 0, mem_en = 0; next line_start scans correctly.
- FB_CLEAR_EN: clr_req with wr_req held -> 76800 zero writes, then clr_busy = 0, then the pending wr_ack.
